// File: rtl/bus_arbiter_if.sv
// Bundle of the shared-memory arbiter's signals: two CPU-side masters
// (m0 = data port, m1 = instruction fetch), the single slave bus and the
// pipeline status lines.
// modport master : the arbiter's own view. It owns the slave bus and
//                  answers both CPU ports.
// modport slave  : the surrounding system's view (CPU ports plus memory).
interface bus_arbiter_if;
  // data port (MEM stage)
  logic        m0_req_i;
  logic        m0_we_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wdata_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_rdata_o;
  logic        m0_ack_o;
  // instruction fetch port (read-only)
  logic        m1_req_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_rdata_o;
  logic        m1_ack_o;
  // shared memory bus
  logic        s_req_o;
  logic        s_we_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_rdata_i;
  logic        s_ack_i;
  // status
  logic        hold_o;
  logic        err_o;

  modport master (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_sel_i,
    output m0_rdata_o, m0_ack_o,
    input  m1_req_i, m1_addr_i,
    output m1_rdata_o, m1_ack_o,
    output s_req_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o,
    input  s_rdata_i, s_ack_i,
    output hold_o, err_o
  );

  modport slave (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_sel_i,
    input  m0_rdata_o, m0_ack_o,
    output m1_req_i, m1_addr_i,
    input  m1_rdata_o, m1_ack_o,
    input  s_req_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o,
    output s_rdata_i, s_ack_i,
    input  hold_o, err_o
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master, one-slave bus arbiter for a small CPU: the data port (m0)
// and the instruction fetch port (m1) share one memory bus. Ties are
// broken against whichever master was granted last, and a master is never
// re-granted straight out of its own ack cycle, so two busy masters
// strictly alternate.
// Optional feature: define ARB_TIMEOUT_EN to abort a grant whose slave
// has not acked within TIMEOUT_CYCLES cycles (the master gets an ack with
// zero data and err_o pulses). Without it a grant waits forever.
// Reset (rst) is asynchronous and active-low.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } state_t;

  // last_grant encoding: 0 = m0 was granted last, 1 = m1 was granted last
  localparam logic LG_M0 = 1'b0;
  localparam logic LG_M1 = 1'b1;

  // The timeout counter is 8 bits wide; reject limits it cannot represent.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES must be within 2..255");
  end

  state_t state_reg, state_next;
  logic   last_grant_reg, last_grant_next;
  logic   granted_req;  // request line of the currently granted master
  logic   timeout;      // grant is being aborted this cycle
  logic   done;         // granted transfer finishes this cycle
  logic   m0_ack, m1_ack;

  assign granted_req = (state_reg == GNT_M0) ? bus.m0_req_i :
                       (state_reg == GNT_M1) ? bus.m1_req_i : 1'b0;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_reg;

  // Only a still-requesting master can time out; a dropped request is an abort.
  assign timeout = granted_req && !bus.s_ack_i && (count_reg == TIMEOUT_LAST);

  // Wait-cycle counter: zero on every new grant, counts unacked GNT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= 8'd0;
    end else if (state_reg == IDLE || state_next != state_reg) begin
      count_reg <= 8'd0;
    end else if (!bus.s_ack_i) begin
      count_reg <= count_reg + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign done = bus.s_ack_i || timeout;

  // State and fairness registers; reset favours m0 on the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= LG_M1;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Next-state arbitration: fresh grants from IDLE, hand-over on completion,
  // fall back to IDLE when the granted master abandons its request.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (bus.m0_req_i && (!bus.m1_req_i || last_grant_reg == LG_M1)) begin
          state_next      = GNT_M0;
          last_grant_next = LG_M0;
        end else if (bus.m1_req_i) begin
          state_next      = GNT_M1;
          last_grant_next = LG_M1;
        end
      end
      GNT_M0: begin
        if (done) begin
          if (bus.m1_req_i) begin
            state_next      = GNT_M1;
            last_grant_next = LG_M1;
          end else begin
            state_next = IDLE;
          end
        end else if (!bus.m0_req_i) begin
          state_next = IDLE;
        end
      end
      GNT_M1: begin
        if (done) begin
          if (bus.m0_req_i) begin
            state_next      = GNT_M0;
            last_grant_next = LG_M0;
          end else begin
            state_next = IDLE;
          end
        end else if (!bus.m1_req_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus steering: the granted master drives the slave bus, slave responses
  // route back only to it; fetches are full-word reads.
  always_comb begin
    bus.s_req_o    = 1'b0;
    bus.s_we_o     = 1'b0;
    bus.s_addr_o   = 32'd0;
    bus.s_wdata_o  = 32'd0;
    bus.s_sel_o    = 4'h0;
    bus.m0_rdata_o = 32'd0;
    bus.m1_rdata_o = 32'd0;
    m0_ack         = 1'b0;
    m1_ack         = 1'b0;
    case (state_reg)
      GNT_M0: begin
        bus.s_req_o    = bus.m0_req_i && !timeout;
        bus.s_we_o     = bus.m0_we_i;
        bus.s_addr_o   = bus.m0_addr_i;
        bus.s_wdata_o  = bus.m0_wdata_i;
        bus.s_sel_o    = bus.m0_sel_i;
        m0_ack         = done;
        bus.m0_rdata_o = timeout ? 32'd0 : bus.s_rdata_i;
      end
      GNT_M1: begin
        bus.s_req_o    = bus.m1_req_i && !timeout;
        bus.s_addr_o   = bus.m1_addr_i;
        bus.s_sel_o    = 4'hF;
        m1_ack         = done;
        bus.m1_rdata_o = timeout ? 32'd0 : bus.s_rdata_i;
      end
      default: ;
    endcase
  end

  assign bus.m0_ack_o = m0_ack;
  assign bus.m1_ack_o = m1_ack;
  assign bus.err_o    = timeout;
  assign bus.hold_o   = (bus.m0_req_i && !m0_ack) || (bus.m1_req_i && !m1_ack);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter. Inputs change 1 time unit after a
// rising edge; outputs are sampled 1 unit later, well clear of the edge.
// Timeout expectations depend on whether ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  bus_arbiter_if bus();

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m0_req_i   = 1'b0;
    bus.m0_we_i    = 1'b0;
    bus.m0_addr_i  = 32'd0;
    bus.m0_wdata_i = 32'd0;
    bus.m0_sel_i   = 4'h0;
    bus.m1_req_i   = 1'b0;
    bus.m1_addr_i  = 32'd0;
    bus.s_rdata_i  = 32'd0;
    bus.s_ack_i    = 1'b0;
  endtask

  // All outputs zero while reset is held, even with a stray slave ack.
  task automatic test_reset();
    logic [137:0] v;
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    bus.s_ack_i = 1'b1;
    #1;
    v = {bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_wdata_o, bus.s_sel_o,
         bus.m0_rdata_o, bus.m0_ack_o, bus.m1_rdata_o, bus.m1_ack_o,
         bus.hold_o, bus.err_o};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", v);
    end
    bus.s_ack_i = 1'b0;
    rst = 1'b1;
    $display("txn reset released");
  endtask

  // Tie straight after reset: m0 write first, m1 fetch back-to-back.
  task automatic test_tie();
    logic [72:0] v;
    step();
    bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b1; bus.m0_addr_i = 32'h0000_1000;
    bus.m0_wdata_i = 32'hDEAD_BEEF; bus.m0_sel_i = 4'hF;
    bus.m1_req_i = 1'b1; bus.m1_addr_i = 32'h0000_0080;
    #1;
    checks++;
    if ({bus.s_req_o, bus.hold_o} !== 2'b01) begin
      failures++;
      $display("FAIL tie_request_cycle got=%b exp=01", {bus.s_req_o, bus.hold_o});
    end
    step();
    bus.s_ack_i = 1'b1;
    #1;
    v = {bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_wdata_o, bus.s_sel_o,
         bus.m0_ack_o, bus.m1_ack_o, bus.hold_o};
    checks++;
    if (v !== {1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL tie_m0_grant got=%h exp=%h", v,
               {1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b1});
    end
    $display("txn tie m0 write addr=%h ack=%b", bus.s_addr_o, bus.m0_ack_o);
    step();
    bus.m0_req_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_addr_i = 32'd0;
    bus.m0_wdata_i = 32'd0; bus.m0_sel_i = 4'h0;
    bus.s_ack_i = 1'b0;
    #1;
    v = {bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_wdata_o, bus.s_sel_o,
         bus.m0_ack_o, bus.m1_ack_o, bus.hold_o};
    checks++;
    if (v !== {1'b1, 1'b0, 32'h0000_0080, 32'd0, 4'hF, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL tie_m1_back_to_back got=%h exp=%h", v,
               {1'b1, 1'b0, 32'h0000_0080, 32'd0, 4'hF, 1'b0, 1'b0, 1'b1});
    end
    step();
    bus.s_ack_i = 1'b1; bus.s_rdata_i = 32'h0000_1234;
    #1;
    checks++;
    if ({bus.m1_ack_o, bus.m1_rdata_o, bus.m0_ack_o, bus.m0_rdata_o, bus.hold_o} !==
        {1'b1, 32'h0000_1234, 1'b0, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL tie_m1_ack got=%h exp=%h",
               {bus.m1_ack_o, bus.m1_rdata_o, bus.m0_ack_o, bus.m0_rdata_o, bus.hold_o},
               {1'b1, 32'h0000_1234, 1'b0, 32'd0, 1'b0});
    end
    $display("txn tie m1 fetch addr=%h ack=%b", bus.s_addr_o, bus.m1_ack_o);
    step();
    clear_inputs();
    #1;
    checks++;
    if ({bus.s_req_o, bus.s_addr_o} !== 33'd0) begin
      failures++;
      $display("FAIL tie_return_idle got=%h exp=0", {bus.s_req_o, bus.s_addr_o});
    end
  endtask

  // Single fetch acked in its first grant cycle; stray ack in IDLE ignored.
  task automatic test_single_fetch();
    step();
    bus.m1_req_i = 1'b1; bus.m1_addr_i = 32'h0000_0040;
    step();
    bus.s_ack_i = 1'b1; bus.s_rdata_i = 32'h0010_0093;
    #1;
    checks++;
    if ({bus.s_req_o, bus.s_addr_o, bus.s_we_o, bus.s_sel_o, bus.m1_ack_o, bus.m1_rdata_o, bus.hold_o} !==
        {1'b1, 32'h0000_0040, 1'b0, 4'hF, 1'b1, 32'h0010_0093, 1'b0}) begin
      failures++;
      $display("FAIL fetch_ack_cycle got=%h exp=%h",
               {bus.s_req_o, bus.s_addr_o, bus.s_we_o, bus.s_sel_o, bus.m1_ack_o, bus.m1_rdata_o, bus.hold_o},
               {1'b1, 32'h0000_0040, 1'b0, 4'hF, 1'b1, 32'h0010_0093, 1'b0});
    end
    $display("txn fetch addr=%h rdata=%h", bus.s_addr_o, bus.m1_rdata_o);
    step();
    bus.m1_req_i = 1'b0;  // address left driven: IDLE must not show it
    bus.s_rdata_i = 32'hFFFF_FFFF;  // slave ack still high: must be ignored
    #1;
    checks++;
    if ({bus.s_req_o, bus.s_addr_o, bus.m0_ack_o, bus.m1_ack_o, bus.m1_rdata_o} !== 67'd0) begin
      failures++;
      $display("FAIL fetch_idle_after_ack got=%h exp=0",
               {bus.s_req_o, bus.s_addr_o, bus.m0_ack_o, bus.m1_ack_o, bus.m1_rdata_o});
    end
    clear_inputs();
  endtask

  // Both masters requesting continuously: grants must alternate.
  task automatic test_fairness();
    logic [31:0] exp_addr;
    logic        exp_m0;
    step();
    bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'h0000_0100; bus.m0_sel_i = 4'hF;
    bus.m1_req_i = 1'b1; bus.m1_addr_i = 32'h0000_0200;
    bus.s_ack_i = 1'b1;
    #1;
    checks++;
    if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b00) begin
      failures++;
      $display("FAIL fair_idle_ack_ignored got=%b exp=00", {bus.m0_ack_o, bus.m1_ack_o});
    end
    for (int k = 0; k < 8; k++) begin
      step();
      bus.s_rdata_i = 32'(k);
      #1;
      exp_m0   = (k % 2 == 0);
      exp_addr = exp_m0 ? 32'h0000_0100 : 32'h0000_0200;
      checks++;
      if ({bus.s_addr_o, bus.m0_ack_o, bus.m1_ack_o} !== {exp_addr, exp_m0, !exp_m0}) begin
        failures++;
        $display("FAIL fair_grant_%0d got=%h exp=%h", k,
                 {bus.s_addr_o, bus.m0_ack_o, bus.m1_ack_o}, {exp_addr, exp_m0, !exp_m0});
      end
      $display("txn fair %0d addr=%h m0_ack=%b m1_ack=%b", k, bus.s_addr_o, bus.m0_ack_o, bus.m1_ack_o);
    end
    // m0 was just re-granted; dropping both requests aborts it without ack
    step();
    bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0; bus.s_ack_i = 1'b0;
    #1;
    checks++;
    if ({bus.s_req_o, bus.m0_ack_o, bus.m1_ack_o, bus.hold_o} !== 4'b0000) begin
      failures++;
      $display("FAIL fair_abort got=%b exp=0000", {bus.s_req_o, bus.m0_ack_o, bus.m1_ack_o, bus.hold_o});
    end
    step();
    #1;
    checks++;
    if (bus.s_addr_o !== 32'd0) begin
      failures++;
      $display("FAIL fair_abort_idle got=%h exp=0", bus.s_addr_o);
    end
    clear_inputs();
  endtask

  // Slave inserts three wait states before acking an m0 read.
  task automatic test_wait_states();
    int acks = 0;
    step();
    bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b0; bus.m0_addr_i = 32'h0000_2000; bus.m0_sel_i = 4'h3;
    #1;
    checks++;
    if ({bus.s_req_o, bus.hold_o} !== 2'b01) begin
      failures++;
      $display("FAIL wait_request_cycle got=%b exp=01", {bus.s_req_o, bus.hold_o});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      bus.s_ack_i   = (i == 3);
      bus.s_rdata_i = (i == 3) ? 32'h0000_CAFE : 32'd0;
      #1;
      if (bus.m0_ack_o === 1'b1) acks++;
      checks++;
      if ({bus.s_req_o, bus.s_addr_o, bus.hold_o, bus.m0_ack_o, bus.m0_rdata_o} !==
          {1'b1, 32'h0000_2000, (i != 3), (i == 3), bus.s_rdata_i}) begin
        failures++;
        $display("FAIL wait_cycle_%0d got=%h exp=%h", i,
                 {bus.s_req_o, bus.s_addr_o, bus.hold_o, bus.m0_ack_o, bus.m0_rdata_o},
                 {1'b1, 32'h0000_2000, (i != 3), (i == 3), bus.s_rdata_i});
      end
    end
    $display("txn wait-state read addr=%h", bus.s_addr_o);
    step();
    clear_inputs();
    #1;
    if (bus.m0_ack_o === 1'b1) acks++;
    checks++;
    if ({bus.s_req_o, 32'(acks)} !== {1'b0, 32'd1}) begin
      failures++;
      $display("FAIL wait_single_ack got=%h exp=%h", {bus.s_req_o, 32'(acks)}, {1'b0, 32'd1});
    end
  endtask

  // Slave never acks m0: abort after the limit, or wait forever without it.
  task automatic test_timeout();
    step();
    bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'h0000_3000; bus.m0_sel_i = 4'hF;
    bus.s_rdata_i = 32'hFFFF_FFFF;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      checks++;
      if ({bus.s_req_o, bus.m0_ack_o, bus.err_o, bus.m0_rdata_o} !==
          {(i != 3), (i == 3), (i == 3), ((i == 3) ? 32'd0 : 32'hFFFF_FFFF)}) begin
        failures++;
        $display("FAIL timeout_cycle_%0d got=%h exp=%h", i,
                 {bus.s_req_o, bus.m0_ack_o, bus.err_o, bus.m0_rdata_o},
                 {(i != 3), (i == 3), (i == 3), ((i == 3) ? 32'd0 : 32'hFFFF_FFFF)});
      end
    end
    $display("txn timeout abort addr=%h", bus.m0_addr_i);
    step();
    clear_inputs();
    #1;
    checks++;
    if ({bus.s_req_o, bus.s_addr_o, bus.err_o} !== 34'd0) begin
      failures++;
      $display("FAIL timeout_idle got=%h exp=0", {bus.s_req_o, bus.s_addr_o, bus.err_o});
    end
`else
    begin
      int bad = 0;
      for (int i = 0; i < 300; i++) begin
        step();
        if (bus.err_o !== 1'b0 || bus.m0_ack_o !== 1'b0) bad++;
      end
      checks++;
      if ({bus.s_req_o, bus.hold_o, bus.err_o, 32'(bad)} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
        failures++;
        $display("FAIL timeout_disabled_wait got=%h exp=%h",
                 {bus.s_req_o, bus.hold_o, bus.err_o, 32'(bad)}, {1'b1, 1'b1, 1'b0, 32'd0});
      end
      $display("txn no-timeout still waiting after 300 cycles addr=%h", bus.s_addr_o);
    end
    step();
    clear_inputs();
    step();
`endif
  endtask

  // Reset between edges during an m1 grant kills the bus request at once.
  task automatic test_async_reset();
    step();
    bus.m1_req_i = 1'b1; bus.m1_addr_i = 32'h0000_0044;
    step();
    #1;
    checks++;
    if (bus.s_req_o !== 1'b1) begin
      failures++;
      $display("FAIL areset_granted got=%b exp=1", bus.s_req_o);
    end
    #2;
    bus.s_ack_i = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.s_req_o, bus.s_addr_o, bus.m1_ack_o, bus.m1_rdata_o} !== 66'd0) begin
      failures++;
      $display("FAIL areset_drop got=%h exp=0",
               {bus.s_req_o, bus.s_addr_o, bus.m1_ack_o, bus.m1_rdata_o});
    end
    $display("txn reset mid-fetch addr=%h", bus.m1_addr_i);
    clear_inputs();
    step();
    rst = 1'b1;
    bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'h0000_0010; bus.m0_sel_i = 4'hF;
    bus.m1_req_i = 1'b1; bus.m1_addr_i = 32'h0000_0020;
    step();
    bus.s_ack_i = 1'b1;
    #1;
    checks++;
    if ({bus.s_addr_o, bus.m0_ack_o, bus.m1_ack_o} !== {32'h0000_0010, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL areset_tie_m0 got=%h exp=%h",
               {bus.s_addr_o, bus.m0_ack_o, bus.m1_ack_o}, {32'h0000_0010, 1'b1, 1'b0});
    end
    $display("txn post-reset tie m0 addr=%h", bus.s_addr_o);
    step();
    bus.m0_req_i = 1'b0;
    #1;
    checks++;
    if ({bus.s_addr_o, bus.m0_ack_o, bus.m1_ack_o} !== {32'h0000_0020, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL areset_tie_m1 got=%h exp=%h",
               {bus.s_addr_o, bus.m0_ack_o, bus.m1_ack_o}, {32'h0000_0020, 1'b0, 1'b1});
    end
    $display("txn post-reset tie m1 addr=%h", bus.s_addr_o);
    step();
    clear_inputs();
    #1;
    checks++;
    if ({bus.s_req_o, bus.hold_o} !== 2'b00) begin
      failures++;
      $display("FAIL areset_final_idle got=%b exp=00", {bus.s_req_o, bus.hold_o});
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single_fetch();
    test_fairness();
    test_wait_states();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the slave wait-cycle limit before abort (range 2..255, held in an 8-bit counter).
REQ-002 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port m0_req_i  input  1  data-port (MEM stage) request; held until ack.
REQ-005 SHALL have port m0_we_i  input  1  data-port write enable.
REQ-006 SHALL have port m0_addr_i  input  32  data-port address.
REQ-007 SHALL have port m0_wdata_i  input  32  data-port write data.
REQ-008 SHALL have port m0_sel_i  input  4  data-port byte lanes.
REQ-009 SHALL have port m0_rdata_o  output  32  data-port read data.
REQ-010 SHALL have port m0_ack_o  output  1  data-port completion pulse.
REQ-011 SHALL have port m1_req_i  input  1  instruction-fetch request (read-only); held until ack.
REQ-012 SHALL have port m1_addr_i  input  32  fetch address (pc).
REQ-013 SHALL have port m1_rdata_o  output  32  fetched instruction.
REQ-014 SHALL have port m1_ack_o  output  1  fetch completion pulse.
REQ-015 SHALL have slave ports s_req_o(1), s_we_o(1), s_addr_o(32), s_wdata_o(32), s_sel_o(4) as outputs, and s_rdata_i(32), s_ack_i(1) as inputs, forming the single shared memory bus.
REQ-016 SHALL have port hold_o  output  1  pipeline stall request.
REQ-017 SHALL have port err_o  output  1  timeout-abort pulse.

Function
REQ-018 SHALL implement a state machine with states IDLE, GNT_M0 and GNT_M1, plus a 1-bit last_grant register.
- IDLE, one request: SHALL grant that master at the next edge.
- IDLE, both requesting: SHALL grant the master that is not last_grant.
- last_grant SHALL update on every grant.
REQ-019 In GNT_Mx, s_req_o SHALL equal mx_req_i and s_addr_o SHALL equal mx_addr_i.
- GNT_M0: s_we_o, s_wdata_o and s_sel_o SHALL follow m0.
- GNT_M1: s_we_o=0, s_wdata_o=0 and s_sel_o=4'hF.
- IDLE: all s_* outputs SHALL be 0.
REQ-020 In GNT_Mx, mx_ack_o SHALL equal s_ack_i and mx_rdata_o SHALL equal s_rdata_i, both combinationally.
- The non-granted master's ack_o and rdata_o SHALL be 0.
REQ-021 On the s_ack_i cycle in GNT_Mx:
- if the other master is requesting, the next state SHALL be GNT of the other master (back-to-back);
- otherwise the next state SHALL be IDLE.
- The same master SHALL never be re-granted directly from its own ack cycle.
REQ-022 Latency: a request first seen at edge n SHALL be granted after edge n, so s_req_o rises in cycle n+1. The earliest ack is in cycle n+1.
REQ-023 If the granted master drops req before ack (abort), the arbiter SHALL return to IDLE at the next edge with no ack issued.
REQ-024 hold_o SHALL equal (m0_req_i & ~m0_ack_o) | (m1_req_i & ~m1_ack_o), combinationally.
REQ-025 s_ack_i while in IDLE SHALL be ignored: no ack is forwarded to either master.

Reset
REQ-026 While rst=0, the arbiter SHALL force state=IDLE, last_grant=M1 (so m0 wins the first tie), and timeout counter=0.
- With no requests, all outputs SHALL read 0.
REQ-027 Reset asserted mid-transaction SHALL drop s_req_o immediately (asynchronously) and discard the transaction; no ack is issued.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN SHALL compile the timeout feature in or out.
REQ-029 With ARB_TIMEOUT_EN defined:
- the counter SHALL clear on each grant and increment each GNT cycle without s_ack_i;
- in the cycle where count reaches TIMEOUT_CYCLES-1 without ack, mx_ack_o=1, mx_rdata_o=0, err_o=1 and s_req_o=0;
- the next state SHALL then follow REQ-021 arbitration.
REQ-030 Without ARB_TIMEOUT_EN:
- there SHALL be no counter logic;
- err_o SHALL be tied 0;
- a grant SHALL wait indefinitely for s_ack_i.

Verification
REQ-031 Single fetch: m1_req_i=1, m1_addr_i=32'h0000_0040, slave acks in cycle 1 with s_rdata_i=32'h0010_0093 -> m1_ack_o=1, m1_rdata_o=32'h0010_0093 in that cycle; state IDLE the next cycle.
REQ-032 Tie after reset: m0 (write, addr 32'h0000_1000, wdata 32'hDEAD_BEEF, sel 4'hF) and m1 request together -> m0 granted first with s_we_o=1; m1 granted back-to-back on the cycle after m0's ack; hold_o=1 until m1_ack_o.
REQ-033 Fairness: both masters requesting continuously for 8 transactions -> grants alternate M0, M1, M0, ...; no master is served twice consecutively.
REQ-034 Wait states: slave delays ack by 3 cycles -> s_req_o, s_addr_o and hold_o stay stable for 4 cycles; exactly one ack pulse.
REQ-035 Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave never acks m0 -> in the 4th GNT cycle m0_ack_o=1, err_o=1, m0_rdata_o=0; next state IDLE. Without the macro: still waiting after 300 cycles, err_o=0.
REQ-036 Async reset: rst driven 0 mid-GNT_M1 between clock edges -> s_req_o=0 immediately; after release, a tie grants M0.
